// File: rtl/suma_serie_if.sv
// Handshake/operand bundle for the bit-serial adder/subtractor.
// The master side drives operands and start. The slave side returns status and the result.
interface suma_serie_if #(parameter int WIDTH = 8);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (output start, op, a, b,
                  input  busy, done, result, cout, overflow);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, cout, overflow);
endinterface

// File: rtl/suma_serie.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// Define SUMA_SERIE_OVF_EN to build the two's-complement overflow flag; otherwise it is tied to 0.
module suma_serie #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  suma_serie_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, result_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             s, c_o, last;

  // Full-adder cell
  assign s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_o  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Sum bits enter A at the MSB as its operand bits leave at the LSB.
  // After WIDTH shifts, A holds the complete sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sh  <= bus.a;
          b_sh  <= bus.op ? ~bus.b : bus.b;
          carry <= bus.op;
          cnt   <= '0;
        end
        RUN: begin
          a_sh  <= {s, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= c_o;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result_q <= {s, a_sh[WIDTH-1:1]};
            cout_q   <= c_o;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUMA_SERIE_OVF_EN
  logic ovf_q;
  // On the last bit, carry holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                      ovf_q <= 1'b0;
    else if ((state == RUN) && last) ovf_q <= c_o ^ carry;
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_suma_serie.sv
// Self-checking bench for suma_serie: directed vectors, random operations, start held high, and reset during RUN.
module tb_suma_serie;
  localparam int W = 8;
`ifdef SUMA_SERIE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [W-1:0] exp_res;
  logic         exp_cout, exp_ovf;

  suma_serie_if #(.WIDTH(W)) bus();
  suma_serie #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: integer arithmetic on the operand values. Returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int m, ia, ib, sa, sb, r, t, res;
    logic c, v;
    m  = 1 << W;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= m / 2) ? ia - m : ia;
    sb = (ib >= m / 2) ? ib - m : ib;
    r  = op ? ia - ib : ia + ib;
    res = (r + m) % m;
    c  = op ? (ia >= ib) : (r >= m);
    t  = op ? sa - sb : sa + sb;
    v  = OVF_EN && ((t > m / 2 - 1) || (t < -(m / 2)));
    return {v, c, W'(res)};
  endfunction

  // Runs one operation. The task is entered at a negedge with the DUT idle and returns at the idle negedge after done.
  // With hold set, start stays high and the operands are scrambled while the DUT is busy.
  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input string tag);
    logic [W+1:0] e;
    e = model(op, a, b);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (hold) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom);
      end else bus.start = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== exp_res ||
          bus.cout !== exp_cout || bus.overflow !== exp_ovf) begin
        n_fail++;
        $display("FAIL %s run cyc %0d: busy=%b done=%b result=%h cout=%b ovf=%b, want busy=1 done=0 result=%h cout=%b ovf=%b",
                 tag, k, bus.busy, bus.done, bus.result, bus.cout, bus.overflow, exp_res, exp_cout, exp_ovf);
      end
    end
    @(negedge clk);
    {exp_ovf, exp_cout, exp_res} = e;
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp_res ||
        bus.cout !== exp_cout || bus.overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s done (op=%b a=%h b=%h): done=%b busy=%b result=%h cout=%b ovf=%b, want done=1 busy=0 result=%h cout=%b ovf=%b",
               tag, op, a, b, bus.done, bus.busy, bus.result, bus.cout, bus.overflow, exp_res, exp_cout, exp_ovf);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_res ||
        bus.cout !== exp_cout || bus.overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s idle: done=%b busy=%b result=%h cout=%b ovf=%b, want done=0 busy=0 result=%h cout=%b ovf=%b",
               tag, bus.done, bus.busy, bus.result, bus.cout, bus.overflow, exp_res, exp_cout, exp_ovf);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    {exp_ovf, exp_cout, exp_res} = '0;
    #2;
    n_tests++;
    if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset values: busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.result, bus.cout, bus.overflow);
    end
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset start ignored: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(1'b0, 8'd100, 8'd27,  1'b0, "add_100_27");
    do_op(1'b0, 8'd200, 8'd100, 1'b0, "add_200_100");
    do_op(1'b1, 8'd5,   8'd7,   1'b0, "sub_5_7");
    do_op(1'b1, 8'd7,   8'd5,   1'b0, "sub_7_5");
    do_op(1'b0, 8'h7F,  8'h01,  1'b0, "add_7f_01");
    do_op(1'b0, 8'hFF,  8'h01,  1'b0, "add_ff_01");
    do_op(1'b1, 8'h00,  8'h00,  1'b0, "sub_0_0");
    do_op(1'b1, 8'h80,  8'h01,  1'b0, "sub_80_01");
    do_op(1'b0, 8'h80,  8'h80,  1'b0, "add_80_80");
    do_op(1'b1, 8'h00,  8'hFF,  1'b0, "sub_0_ff");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_op(1'($urandom), W'($urandom), W'($urandom), 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 8'd100, 8'd27, 1'b1, "held_1");
    do_op(1'b1, 8'd3,   8'd9,  1'b1, "held_2");
    do_op(1'b0, 8'h7F,  8'h7F, 1'b1, "held_3");
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_midrun_reset();
    do_op(1'b0, 8'h55, 8'h22, 1'b0, "pre_reset");
    bus.op = 1'b0; bus.a = 8'hAA; bus.b = 8'h11; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    {exp_ovf, exp_cout, exp_res} = '0;
    n_tests++;
    if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL midrun reset: busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.result, bus.cout, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== '0) begin
        n_fail++;
        $display("FAIL post reset quiet cyc %0d: done=%b busy=%b result=%h, want 0 0 00",
                 k, bus.done, bus.busy, bus.result);
      end
    end
    do_op(1'b0, 8'd3, 8'd4, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/suma_serie.md
# suma_serie

Bit-serial adder/subtractor for the calculator datapath. It accepts two WIDTH-bit operands with a start pulse and feeds them LSB-first, one bit per clock, into a single 1-bit full-adder cell (inputs a, b, cin; outputs s, cout). It registers the carry between bits and reassembles the sum bits into a parallel result. It sits between the operand-entry registers and the result display/register stage.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b), 1 = subtract (a−b)
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference, held until next accepted start
- cout  output  1  final carry out; for subtract 1 = no borrow
- overflow  output  1  two's-complement overflow (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at a rising edge → load shift register A←a, B←(op ? ~b : b), carry←op, bit counter←0, go RUN. start=0 → stay.
- RUN: each edge: the full-adder cell sees A[0], B[0], carry; sum bit shifted into result shift register at MSB (right shift); carry←cell cout; A, B shift right; counter++. When counter reaches WIDTH−1 (last bit processed this edge) → DONE.
- At the last RUN edge also capture: cout←cell cout, overflow←cell cout XOR carry-in of MSB bit, result register final.
- DONE: done=1 for exactly one cycle, → IDLE unconditionally.
- start during RUN or DONE ignored (not queued); a, b, op changes after acceptance have no effect.
- Arithmetic: modulo 2^WIDTH; subtraction via a + ~b + 1 using the same cell.
- result/cout/overflow change only on the final RUN edge or reset; stable otherwise.

## Timing
- Reset values: busy 0, done 0, result 0, cout 0, overflow 0, state IDLE, internal carry 0.
- Latency: start sampled at edge E → busy high from E to E+WIDTH; result valid and done=1 in cycle after edge E+WIDTH; next start accepted at edge E+WIDTH+2 earliest (IDLE again).
- Throughput: one operation per WIDTH+2 cycles.
- busy and done are never high simultaneously.
- Reset asserted mid-RUN: immediate (asynchronous) return to IDLE, all outputs to reset values, partial result discarded; no done pulse.
- start held high continuously: a new operation starts each time IDLE is entered.

## Configuration
- SUMA_SERIE_OVF_EN defined: overflow computed as above and registered with result.
- Not defined: overflow output tied to 0; MSB carry-in capture logic omitted; all other behaviour identical.

## Test plan
- WIDTH=8, op=0, a=100, b=27, start pulse → busy 8 cycles, done pulse, result=127, cout=0, overflow=0.
- op=0, a=200, b=100 → result=44 (0x2C), cout=1; with SUMA_SERIE_OVF_EN overflow=0 (−56+100).
- op=1, a=5, b=7 → result=0xFE, cout=0 (borrow); op=1, a=7, b=5 → result=2, cout=1.
- op=0, a=0x7F, b=0x01 → result=0x80, overflow=1 with macro, overflow=0 without.
- Start held high during RUN with changing a/b → ignored; first result correct; new op begins right after DONE.
- rst_n pulsed low at cycle 4 of RUN → outputs 0 immediately, no done; next start a=3, b=4 → result=7.
